// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// No logic; latency and backpressure are defined by the users of these types.
package fetch_pkg;

    localparam logic [31:0] FETCH_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } fetch_entry_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle: fetch side is master, memory is slave.
// Requests are valid/ready; responses arrive in order with no backpressure.
interface if_fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_resp_fifo.sv
// Response buffer: DEPTH x WIDTH synchronous FIFO with flush and occupancy count.
// Latency: push visible at pop_dat next cycle; push while full / pop while empty are ignored.
module fetch_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_rdy,
    output logic                       pop_vld,
    output logic [WIDTH-1:0]           pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int              AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW   = $clog2(DEPTH + 1);
    localparam logic [AW-1:0]   LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_vld && (cnt_q != FULL) && !flush;
    assign do_pop  = pop_rdy && (cnt_q != '0) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only observed once cnt_q says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
    assign pop_vld = (cnt_q != '0);
    assign count   = cnt_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns PC, issues in-order imem reads, buffers {instr, pc+4} for IF/ID.
// Latency: response -> InstrF 1 cycle; IF_Stall holds the head, full buffer blocks issue.
// FETCH_PERF_CNT_EN adds saturating bubble/discard counters.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          BUF_DEPTH       = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               IF_Stall,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    if_fetch_unit_if.master    imem,
    output logic [31:0]        InstrF,
    output logic [31:0]        PCPlus4F,
    output logic               fetch_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_bubble_cnt,
    output logic [31:0]        perf_discard_cnt
`endif
);

    localparam int            CW      = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] MAX_L   = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_L = (CW + 1)'(BUF_DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q;
    logic [31:0]   rsp_pc_q;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] buf_cnt;
    logic [CW:0]   occupancy;
    logic          issue;
    logic          req_fire;
    logic          rsp_keep;
    logic          rsp_drop;
    logic          pop_rdy;
    fetch_entry_t  rsp_entry;
    fetch_entry_t  head;

    // Buffer slots are reserved at issue time, so a returning response always fits.
    assign occupancy = {1'b0, out_q} + {1'b0, buf_cnt};
    assign issue     = (state_q == RUN) && !redirect_i && (out_q < MAX_L) && (occupancy < DEPTH_L);
    assign req_fire  = issue && imem.imem_req_ready;
    assign rsp_keep  = imem.imem_rsp_valid && (state_q == RUN) && !redirect_i;
    assign rsp_drop  = imem.imem_rsp_valid && !rsp_keep;
    assign out_d     = out_q + CW'(req_fire) - CW'(imem.imem_rsp_valid);

    assign imem.imem_req_valid = issue;
    assign imem.imem_addr      = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            if (redirect_i) begin
                pc_q     <= redirect_pc_i;
                rsp_pc_q <= redirect_pc_i;
            end else begin
                if (req_fire) pc_q     <= pc_next(pc_q);
                if (rsp_keep) rsp_pc_q <= pc_next(rsp_pc_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (redirect_i && (out_d != '0)) state_d = DRAIN;
            DRAIN:   if (out_d == '0) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // rsp_pc_q tracks the address of the oldest kept request; responses return in order.
    assign rsp_entry = '{instr: imem.imem_rsp_data, pc_plus4: pc_next(rsp_pc_q)};
    assign pop_rdy   = fetch_valid && !IF_Stall && !redirect_i;

    fetch_resp_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_resp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_i),
        .push_vld (rsp_keep),
        .push_dat (rsp_entry),
        .pop_rdy  (pop_rdy),
        .pop_vld  (fetch_valid),
        .pop_dat  (head),
        .count    (buf_cnt)
    );

    assign InstrF   = fetch_valid ? head.instr    : FETCH_NOP;
    assign PCPlus4F = fetch_valid ? head.pc_plus4 : 32'h0;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubble_cnt  <= '0;
            perf_discard_cnt <= '0;
        end else begin
            if (!IF_Stall && !fetch_valid && (perf_bubble_cnt != '1))
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (rsp_drop && (perf_discard_cnt != '1))
                perf_discard_cnt <= perf_discard_cnt + 32'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = rsp_drop;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed + random bench for if_fetch_unit with an in-order variable-latency memory model
// and a scoreboard of expected {instr, pc+4} entries.
module tb_if_fetch_unit;
    import fetch_pkg::*;

    localparam int MAXO = 2;
    localparam int BUFD = 2;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        IF_Stall;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] InstrF;
    logic [31:0] PCPlus4F;
    logic        fetch_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_discard_cnt;
`endif

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC        (32'h0),
        .MAX_OUTSTANDING (MAXO),
        .BUF_DEPTH       (BUFD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .IF_Stall      (IF_Stall),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (bus.master),
        .InstrF        (InstrF),
        .PCPlus4F      (PCPlus4F),
        .fetch_valid   (fetch_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_bubble_cnt  (perf_bubble_cnt),
        .perf_discard_cnt (perf_discard_cnt)
`endif
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    int           tick_no = 0;
    int           mem_lat = 1;
    int           m_out = 0;
    bit           m_idle = 1'b1;
    bit           m_drain = 1'b0;
    int           m_bubbles = 0;
    int           m_drops = 0;
    logic [31:0]  exp_issue_pc = 32'h0;
    fetch_entry_t exp_q[$];
    pend_t        pend[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h tick=%0d", tag, obs, exp, tick_no);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        pend.delete();
        m_out        = 0;
        m_idle       = 1'b1;
        m_drain      = 1'b0;
        m_bubbles    = 0;
        m_drops      = 0;
        exp_issue_pc = 32'h0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        chk("rst_instr", InstrF, 32'h0);
        chk("rst_pcplus4", PCPlus4F, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_bubble", perf_bubble_cnt, 32'h0);
        chk("rst_perf_discard", perf_discard_cnt, 32'h0);
`endif
    endtask

    // One clock cycle: drive the memory response, check outputs, advance the model.
    task automatic tick();
        bit          rv;
        bit          hs;
        bit          fv_exp;
        bit          exp_req;
        logic [31:0] ra;
        rv = 1'b0;
        ra = 32'h0;
        if (pend.size() > 0 && pend[0].due <= tick_no) begin
            rv = 1'b1;
            ra = pend[0].addr;
            void'(pend.pop_front());
        end
        bus.imem_rsp_valid = rv;
        bus.imem_rsp_data  = rv ? mem_word(ra) : 32'h0;
        #1;
        fv_exp = (exp_q.size() > 0);
        chk("fetch_valid", 32'(fetch_valid), 32'(fv_exp));
        if (fv_exp) begin
            chk("instr", InstrF, exp_q[0].instr);
            chk("pcplus4", PCPlus4F, exp_q[0].pc_plus4);
        end else begin
            chk("bubble_instr", InstrF, FETCH_NOP);
            chk("bubble_pcplus4", PCPlus4F, 32'h0);
        end
        exp_req = !m_idle && !m_drain && !redirect_i && (m_out < MAXO) &&
                  (m_out + exp_q.size() < BUFD);
        chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
        if (bus.imem_req_valid) chk("req_addr", bus.imem_addr, exp_issue_pc);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_bubble", perf_bubble_cnt, 32'(m_bubbles));
        chk("perf_discard", perf_discard_cnt, 32'(m_drops));
`endif
        if (!IF_Stall && !fv_exp) m_bubbles++;
        hs = bus.imem_req_valid && bus.imem_req_ready;
        if (hs) begin
            pend.push_back('{addr: exp_issue_pc, due: tick_no + mem_lat});
            exp_issue_pc = exp_issue_pc + PC_STEP;
            m_out++;
        end
        if (fv_exp && !IF_Stall && !redirect_i) void'(exp_q.pop_front());
        if (rv) begin
            m_out--;
            if (m_drain || redirect_i) m_drops++;
            else exp_q.push_back('{instr: mem_word(ra), pc_plus4: ra + PC_STEP});
        end
        if (redirect_i) begin
            exp_q.delete();
            exp_issue_pc = redirect_pc_i;
            m_drain = (m_out > 0);
        end else if (m_drain && m_out == 0) begin
            m_drain = 1'b0;
        end
        m_idle = 1'b0;
        tick_no++;
        @(negedge clk);
        redirect_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        IF_Stall       = 1'b0;
        redirect_i     = 1'b0;
        redirect_pc_i  = 32'h0;
        bus.imem_req_ready = 1'b1;
        model_clear();
        #1;
        chk_reset_outputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: streaming from reset, first instruction visible on the fourth cycle
        repeat (3) tick();
        #1;
        chk("t1_first_valid", 32'(fetch_valid), 32'h1);
        chk("t1_first_pcplus4", PCPlus4F, 32'h4);
        chk("t1_first_instr", InstrF, mem_word(32'h0));
        repeat (12) tick();

        // 2: stall long enough to fill the buffer, then resume
        IF_Stall = 1'b1;
        repeat (10) tick();
        chk("t2_full_count", 32'(dut.buf_cnt), 32'(BUFD));
        IF_Stall = 1'b0;
        repeat (8) tick();

        // 3: redirect with two requests in flight
        mem_lat = 3;
        for (int i = 0; i < 20 && m_out != 2; i++) tick();
        chk("t3_two_outstanding", 32'(m_out), 32'd2);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        tick();
        chk("t3_drain_state", 32'(dut.state_q), 32'(DRAIN));
        for (int i = 0; i < 20 && exp_q.size() == 0; i++) tick();
        #1;
        chk("t3_first_pcplus4", PCPlus4F, 32'h0000_0104);
        repeat (6) tick();

        // 4: memory refuses requests for 5 cycles
        mem_lat = 1;
        bus.imem_req_ready = 1'b0;
        repeat (5) tick();
        bus.imem_req_ready = 1'b1;
        repeat (6) tick();

        // 5: redirect in the same cycle as a response and a stall
        begin
            int d0;
            d0 = m_drops;
            for (int i = 0; i < 30 && !(pend.size() > 0 && pend[0].due <= tick_no && exp_q.size() > 0); i++)
                tick();
            IF_Stall      = 1'b1;
            redirect_i    = 1'b1;
            redirect_pc_i = 32'h0000_0200;
            tick();
            chk("t5_one_dropped", 32'(m_drops - d0), 32'd1);
            chk("t5_pc_target", bus.imem_addr, 32'h0000_0200);
            chk("t5_flushed", 32'(fetch_valid), 32'h0);
            IF_Stall = 1'b0;
            repeat (8) tick();
        end

        // PC wrap past 2^32
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        tick();
        repeat (12) tick();

        // random stalls, readiness, latency and redirects
        for (int i = 0; i < 300; i++) begin
            IF_Stall           = ($urandom_range(0, 3) == 0);
            bus.imem_req_ready = ($urandom_range(0, 4) != 0);
            mem_lat            = $urandom_range(1, 3);
            if ($urandom_range(0, 24) == 0) begin
                redirect_i    = 1'b1;
                redirect_pc_i = $urandom & 32'hFFFF_FFFC;
            end
            tick();
        end
        IF_Stall = 1'b0;
        bus.imem_req_ready = 1'b1;
        mem_lat = 1;
        repeat (6) tick();

        // 6: asynchronous reset mid-stream, then refetch from RESET_PC
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        #1;
        chk("t6_refetch_pcplus4", PCPlus4F, 32'h4);
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
